// File: rtl/utf8_decoder.sv
// UTF-8 byte stream to Unicode code point decoder with downstream throttling.
// Optional malformed-sequence counter enabled by defining UTF8_DECODER_ERROR_COUNT_EN.
module utf8_decoder #(
  parameter logic [20:0] REPLACEMENT_CHAR = 21'h00FFFD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [20:0] unicode,
  output logic        unicode_available,
  input  logic        unicode_ready
`ifdef UTF8_DECODER_ERROR_COUNT_EN
  ,
  output logic [15:0] error_count
`endif
);

  typedef enum logic {START, CONT} state_t;

  state_t      state, next_state;
  logic        pending, replay, holdoff;
  logic [7:0]  replay_byte;
  logic [1:0]  remaining, next_remaining;
  logic [20:0] acc, next_acc, min_code, next_min, result, next_code, acc_ext;
  logic [7:0]  in_byte;
  logic        take, done, is_error, latch_replay;

  // Both terms are flops, so data_ready changes only on clock edges.
  assign data_ready = !pending && !replay;

  // A byte is consumed either from the input port or, with priority, from the replay register.
  assign take = replay ? !pending : (data_valid && data_ready);

  always_comb begin
    in_byte        = replay ? replay_byte : data;
    acc_ext        = {acc[14:0], in_byte[5:0]};
    next_state     = state;
    next_remaining = remaining;
    next_acc       = acc;
    next_min       = min_code;
    next_code      = 21'd0;
    done           = 1'b0;
    is_error       = 1'b0;
    latch_replay   = 1'b0;
    unique case (state)
      START: begin
        if (in_byte < 8'h80) begin
          done      = 1'b1;
          next_code = {13'd0, in_byte};
        end else if (in_byte >= 8'hC2 && in_byte <= 8'hDF) begin
          next_state     = CONT;
          next_remaining = 2'd1;
          next_acc       = {16'd0, in_byte[4:0]};
          next_min       = 21'h000080;
        end else if (in_byte >= 8'hE0 && in_byte <= 8'hEF) begin
          next_state     = CONT;
          next_remaining = 2'd2;
          next_acc       = {17'd0, in_byte[3:0]};
          next_min       = 21'h000800;
        end else if (in_byte >= 8'hF0 && in_byte <= 8'hF4) begin
          next_state     = CONT;
          next_remaining = 2'd3;
          next_acc       = {18'd0, in_byte[2:0]};
          next_min       = 21'h010000;
        end else begin
          done      = 1'b1;
          is_error  = 1'b1;
          next_code = REPLACEMENT_CHAR;
        end
      end
      CONT: begin
        if (in_byte[7:6] == 2'b10) begin
          next_acc       = acc_ext;
          next_remaining = remaining - 2'd1;
          if (remaining == 2'd1) begin
            done       = 1'b1;
            next_state = START;
            // Reject overlong forms, surrogates and values beyond the Unicode range.
            if (acc_ext < min_code || (acc_ext >= 21'h00D800 && acc_ext <= 21'h00DFFF) ||
                acc_ext > 21'h10FFFF) begin
              is_error  = 1'b1;
              next_code = REPLACEMENT_CHAR;
            end else begin
              next_code = acc_ext;
            end
          end
        end else begin
          done           = 1'b1;
          is_error       = 1'b1;
          next_code      = REPLACEMENT_CHAR;
          latch_replay   = 1'b1;
          next_remaining = 2'd0;
          next_state     = START;
        end
      end
      default: next_state = START;
    endcase
  end

  // Holdoff guarantees a dead cycle between strobes so the consumer's state update is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= START;
      pending           <= 1'b0;
      replay            <= 1'b0;
      holdoff           <= 1'b0;
      replay_byte       <= 8'd0;
      remaining         <= 2'd0;
      acc               <= 21'd0;
      min_code          <= 21'd0;
      result            <= 21'd0;
      unicode           <= 21'd0;
      unicode_available <= 1'b0;
`ifdef UTF8_DECODER_ERROR_COUNT_EN
      error_count       <= 16'd0;
`endif
    end else begin
      unicode_available <= 1'b0;
      if (holdoff) begin
        holdoff <= 1'b0;
      end else if (pending && unicode_ready) begin
        unicode           <= result;
        unicode_available <= 1'b1;
        pending           <= 1'b0;
        holdoff           <= 1'b1;
      end
      if (take) begin
        state     <= next_state;
        remaining <= next_remaining;
        acc       <= next_acc;
        min_code  <= next_min;
        replay    <= latch_replay;
        if (latch_replay) replay_byte <= data;
        if (done) begin
          result  <= next_code;
          pending <= 1'b1;
        end
`ifdef UTF8_DECODER_ERROR_COUNT_EN
        if (is_error && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
`endif
      end
    end
  end

endmodule
